// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Instruction fetch / PC sequencer. Fetches one word from the
//               instruction ROM, holds it until the core consumes it, then
//               computes the next PC from jump/branch controls. Optional
//               target-misalignment trap via IFETCH_MISALIGN_TRAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [13:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Inst,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        exec_done,
  input  logic        Branch,
  input  logic [2:0]  BranchType,
  input  logic        Jump,
  input  logic        Jalr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] imm,
  output logic        misalign
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_ERR   = 2'd3;

  localparam logic [31:0] C_NOP  = 32'h0000_0013;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic        w_taken;
  logic [31:0] w_next_pc;
  logic        w_trap;
  logic        w_retire;

  assign imem_addr = pc[15:2];
  assign pc_plus4  = pc + 32'd4;
  assign w_retire  = (r_state == S_HOLD) && exec_done;

  always_comb begin
    w_taken = 1'b0;
    case (BranchType)
      3'b000:  w_taken = (rs1_data == rs2_data);
      3'b001:  w_taken = (rs1_data != rs2_data);
      3'b100:  w_taken = ($signed(rs1_data) <  $signed(rs2_data));
      3'b101:  w_taken = ($signed(rs1_data) >= $signed(rs2_data));
      3'b110:  w_taken = (rs1_data <  rs2_data);
      3'b111:  w_taken = (rs1_data >= rs2_data);
      default: w_taken = 1'b0;
    endcase
  end

  // Jump outranks Branch; jalr clears bit 0 of the computed target.
  always_comb begin
    w_next_pc = pc_plus4;
    if (Jump) begin
      if (Jalr) w_next_pc = (rs1_data + imm) & 32'hFFFF_FFFE;
      else      w_next_pc = pc + imm;
    end else if (Branch && w_taken) begin
      w_next_pc = pc + imm;
    end
  end

`ifdef IFETCH_MISALIGN_TRAP_EN
  logic r_misalign;

  assign w_trap   = |w_next_pc[1:0];
  assign misalign = r_misalign;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_misalign <= 1'b0;
    else if (w_retire && w_trap) r_misalign <= 1'b1;
  end
`else
  assign w_trap   = 1'b0;
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // exec_done is only looked at in HOLD, so one landing with the ack is dropped.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = S_FETCH;
      S_FETCH: if (imem_ack)  w_state_nxt = S_HOLD;
      S_HOLD:  if (exec_done) w_state_nxt = w_trap ? S_ERR : S_FETCH;
      S_ERR:   w_state_nxt = S_ERR;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req   = (r_state == S_FETCH);
    inst_valid = (r_state == S_HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc   <= 32'h0000_0000;
      Inst <= C_NOP;
    end else begin
      if ((r_state == S_FETCH) && imem_ack) Inst <= imem_rdata;
      if (w_retire && !w_trap)              pc   <= w_next_pc;
    end
  end

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have exactly one clock and an asynchronous, active-low reset; all other ports are synchronous to the clock.
REQ-002 The block SHALL have port `clk`: input, 1 bit, rising-edge clock.
REQ-003 The block SHALL have port `rst_n`: input, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have port `imem_req`: output, 1 bit, fetch request to the instruction ROM.
REQ-005 The block SHALL have port `imem_addr`: output, 14 bits, ROM word address, equal to `pc[15:2]`.
REQ-006 The block SHALL have port `imem_ack`: input, 1 bit, ROM data valid; sampled only while `imem_req` is high.
REQ-007 The block SHALL have port `imem_rdata`: input, 32 bits, ROM read data, valid with `imem_ack`.
REQ-008 The block SHALL have port `Inst`: output, 32 bits, registered instruction presented to the decode/control stage.
REQ-009 The block SHALL have port `inst_valid`: output, 1 bit, high while `Inst` is held for execution.
REQ-010 The block SHALL have port `pc`: output, 32 bits, address of the instruction in `Inst`.
REQ-011 The block SHALL have port `pc_plus4`: output, 32 bits, `pc` + 4, used as the link value for jal/jalr.
REQ-012 The block SHALL have port `exec_done`: input, 1 bit, the core has consumed `Inst` this cycle.
REQ-013 The block SHALL have port `Branch`: input, 1 bit, from the controller.
REQ-014 The block SHALL have port `BranchType`: input, 3 bits, funct3 of the branch, from the controller.
REQ-015 The block SHALL have port `Jump`: input, 1 bit, jal or jalr, from the controller.
REQ-016 The block SHALL have port `Jalr`: input, 1 bit, qualifies `Jump` as jalr.
REQ-017 The block SHALL have port `rs1_data`: input, 32 bits, register operand 1.
REQ-018 The block SHALL have port `rs2_data`: input, 32 bits, register operand 2.
REQ-019 The block SHALL have port `imm`: input, 32 bits, sign-extended immediate.
REQ-020 The block SHALL have port `misalign`: output, 1 bit, sticky target-misalignment flag.

Function
REQ-021 The FSM SHALL have states IDLE, FETCH, HOLD and ERR; IDLE SHALL go to FETCH on the first clock after reset release.
REQ-022 In FETCH the block SHALL hold `imem_req`=1 with a stable `imem_addr` until `imem_ack`; on `imem_ack` it SHALL capture `imem_rdata` into `Inst` and go to HOLD.
REQ-023 In HOLD the block SHALL drive `inst_valid`=1 and keep `Inst` and `pc` stable until `exec_done`.
REQ-024 On `exec_done` in HOLD the block SHALL load `pc` with the next PC and go to FETCH, so `imem_req` rises on the following cycle; minimum issue interval is 3 cycles with a zero-wait ROM.
REQ-025 Next PC when `Jump`&`Jalr` SHALL be (`rs1_data`+`imm`) & 0xFFFF_FFFE.
REQ-026 Next PC when `Jump`&!`Jalr` SHALL be `pc`+`imm`.
REQ-027 Next PC when `Branch` and taken SHALL be `pc`+`imm`; otherwise next PC SHALL be `pc`+4.
REQ-028 Branch taken SHALL be decoded from `BranchType`: 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge, 010/011 never taken.
REQ-029 Jump SHALL have priority over Branch if both are asserted.
REQ-030 All PC arithmetic SHALL be 32-bit and wrap modulo 2^32 (0xFFFF_FFFC+4 = 0x0000_0000).
REQ-031 `imem_ack` outside FETCH and `exec_done` outside HOLD SHALL be ignored.
REQ-032 An `exec_done` in the same cycle that `imem_ack` completes a FETCH SHALL be ignored; HOLD is always entered first.

Reset
REQ-033 `rst_n` low SHALL asynchronously force state IDLE, `pc`=0x0000_0000, `Inst`=0x0000_0013 (nop), `inst_valid`=0, `imem_req`=0 and `misalign`=0.
REQ-034 A reset asserted mid-FETCH SHALL drop `imem_req` immediately, and any later `imem_ack` SHALL be ignored.

Configuration
REQ-035 With macro `IFETCH_MISALIGN_TRAP_EN` defined, a computed next PC with bits [1:0] != 00 SHALL set `misalign`=1 and move the FSM to ERR; `pc` SHALL keep the faulting instruction's address, and the FSM SHALL stay in ERR with `imem_req`=0 and `inst_valid`=0 until reset.
REQ-036 Without `IFETCH_MISALIGN_TRAP_EN`, `misalign` SHALL be tied to 0, the next PC SHALL be loaded unchecked, and `imem_addr` SHALL ignore `pc[1:0]`.

Verification
REQ-037 The bench SHALL cover: reset release with a ROM ack 1 cycle after req -> `imem_addr`=0, `Inst`=ROM[0], `inst_valid`=1, `pc`=0.
REQ-038 The bench SHALL cover: `pc`=0x10, Branch=1, BranchType=100, rs1=0xFFFF_FFFF, rs2=1, imm=0x20, exec_done -> `pc`=0x30; the same case with BranchType=110 -> `pc`=0x14.
REQ-039 The bench SHALL cover: `pc`=0x40, Jump=1, Jalr=1, rs1=0x101, imm=4, exec_done -> `pc`=0x104, and `pc_plus4` before the jump reads 0x44.
REQ-040 The bench SHALL cover: ROM ack held off 5 cycles -> `imem_req` and `imem_addr` stable throughout; spurious `exec_done` in FETCH has no effect.
REQ-041 The bench SHALL cover: with the macro, Jump=1, Jalr=0, `pc`=0x8, imm=2 -> `misalign`=1, state ERR, `pc`=0x8; without the macro -> `pc`=0xA, `misalign`=0.
REQ-042 The bench SHALL cover: `rst_n` pulsed low during a FETCH at `pc`=0x20 -> `imem_req`=0 in the same cycle, and the next fetch is from 0x0.
